// File: rtl/gate2_vector_checker.sv
// Stimulus/response checker for a 2-input gate: walks {a,b} through 00..11 and compares c to TRUTH.
// Optional first-failure log enabled by defining GATE_CHK_FAILLOG_EN.
module gate2_vector_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  TRUTH         = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
`ifdef GATE_CHK_FAILLOG_EN
    output logic       fail_valid,
    output logic [1:0] fail_idx,
`endif
    output logic [1:0] vec_idx
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] err_q, err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       hit;
`ifdef GATE_CHK_FAILLOG_EN
    logic       fv_q, fv_d;
    logic [1:0] fi_q, fi_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef GATE_CHK_FAILLOG_EN
            fv_q    <= 1'b0;
            fi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`ifdef GATE_CHK_FAILLOG_EN
            fv_q    <= fv_d;
            fi_q    <= fi_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
`ifdef GATE_CHK_FAILLOG_EN
        fv_d    = fv_q;
        fi_d    = fi_q;
`endif
        // An X/Z on c makes the condition unknown, so hit stays 0 and it counts as a miss
        hit = 1'b0;
        if (c == TRUTH[idx_q]) hit = 1'b1;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (start) begin
                    state_d = DRIVE;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = 4'd1;
`ifdef GATE_CHK_FAILLOG_EN
                    fv_d    = 1'b0;
                    fi_d    = '0;
`endif
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE) state_d = SAMPLE;
                else                 cnt_d   = cnt_q + 4'd1;
            end
            SAMPLE: begin
                if (!hit) begin
                    err_d = err_q + 3'd1;
`ifdef GATE_CHK_FAILLOG_EN
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        fi_d = idx_q;
                    end
`endif
                end
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = hit && (err_q == '0);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign a       = idx_q[1];
    assign b       = idx_q[0];
    assign vec_idx = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
`ifdef GATE_CHK_FAILLOG_EN
    assign fail_valid = fv_q;
    assign fail_idx   = fi_q;
`endif

endmodule
